// File: rtl/serial_full_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor slice plus a borrow flop,
// LSB first, with a start/busy/done handshake for a controlling FSM.
module serial_full_sub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_br;

   logic             w_ak;
   logic             w_bk;
   logic             w_d;
   logic             w_br_next;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;

   assign w_ak      = r_a[0];
   assign w_bk      = r_b[0];
   assign w_d       = w_ak ^ w_bk ^ r_br;
   assign w_br_next = (~w_ak & w_bk) | (~(w_ak ^ w_bk) & r_br);
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   // Each new difference bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign w_res_next = w_d;
      end else begin : g_res_wn
         assign w_res_next = {w_d, r_res[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_a        <= '0;
         r_b        <= '0;
         r_res      <= '0;
         r_cnt      <= '0;
         r_br       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_br    <= borrow_in;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= StShift;
               end
            end
            StShift: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_res <= w_res_next;
               r_br  <= w_br_next;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  diff       <= w_res_next;
                  borrow_out <= w_br_next;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  r_state    <= StDone;
               end
            end
            StDone: begin
               done    <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_full_sub.md
Name: serial_full_sub

Overview:
- Bit-serial unsigned subtractor: computes a - b - borrow_in one bit per clock, LSB first.
- Uses a single full-subtractor slice and a borrow flip-flop.
- It is the inverse-operation companion to the team's full-adder datapath primitives.
- Sits beside the adder blocks as the area-minimal subtract path; start/done handshake to a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- borrow_in  input  1  initial borrow; captured on accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result, (a - b - borrow_in) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b + borrow_in (unsigned).

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n); all state is clocked on the rising edge of clk.
- Reset values:
  - busy=0, done=0, diff=0, borrow_out=0.
  - State=IDLE; internal shift registers, bit counter and borrow flop all 0.
- States: IDLE, SHIFT, DONE.
- IDLE: when start=1 at an edge:
  - Latch a, b and borrow_in into internal registers (borrow flop = borrow_in).
  - Clear the bit counter and go to SHIFT; busy=1 from that edge.
  - start=0 -> stay in IDLE.
- SHIFT: each edge processes bit k = counter value:
  - d = a_k ^ b_k ^ br.
  - br_next = (~a_k & b_k) | (~(a_k ^ b_k) & br).
  - d shifts into the internal result register MSB-side, so after WIDTH shifts bit 0 sits at the LSB.
  - Operand registers shift right; counter increments.
  - On the edge processing bit WIDTH-1, go to DONE.
- Entering DONE, at the same edge:
  - diff <= completed result; borrow_out <= br_next.
  - busy=0, done=1.
- DONE: lasts exactly one cycle, then returns to IDLE with done=0.
- Latency: start sampled at edge N -> done high from edge N+WIDTH until edge N+WIDTH+1.
  - Throughput: one operation per WIDTH+2 cycles.
- diff and borrow_out update only on entry to DONE and hold until the next DONE; they never show partial results.
- start during SHIFT or DONE is ignored and does not queue. Operand changes after acceptance have no effect.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- Counter is $clog2(WIDTH)+1 bits wide, so WIDTH=1 works: one SHIFT edge, then DONE.
- rst_n low mid-operation:
  - Immediately aborts and returns all outputs and state to reset values.
  - No done pulse is generated for the aborted operation.
- Wrap-around: results are modulo 2^WIDTH; underflow is reported only via borrow_out.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, borrow_in=0, start pulse -> exactly 8 busy cycles, then done=1 for 1 cycle; diff=8'h1E, borrow_out=0.
- a=8'h00, b=8'h01, borrow_in=0 -> diff=8'hFF, borrow_out=1. Then a=8'h10, b=8'h10, borrow_in=1 -> diff=8'hFF, borrow_out=1.
- Start accepted with a=8'hFF, b=8'h00. Pulse start with a=8'h01, b=8'h02 on SHIFT cycle 3 -> that pulse is ignored; diff=8'hFF, borrow_out=0; a single done pulse.
- Start with a=8'h80, b=8'h01, then drive rst_n low for 1 cycle at SHIFT cycle 4 -> busy, done, diff and borrow_out are 0 immediately; no done pulse. A new start afterwards (a=8'h80, b=8'h01) -> diff=8'h7F, borrow_out=0.
- start held high with a=8'h03, b=8'h01 -> done pulses every 10 cycles, diff=8'h02 each time; busy low in the DONE and IDLE cycles between operations.
- Exhaustive sweep with WIDTH=1 and WIDTH=4 over all a, b and borrow_in -> diff and borrow_out match the reference model a - b - borrow_in in every case.
